// File: rtl/i2c_controller_pkg.sv
// Shared types and constants for the single-byte I2C controller.
// Holds the controller state encoding, the quarter-phase encoding and the default target address.
package i2c_controller_pkg;

    localparam int unsigned QUARTERS_PER_BIT = 4;
    localparam logic [6:0]  I2C_DEFAULT_ADDR = 7'h01;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_WRITE     = 4'd4,
        ST_WRITE_ACK = 4'd5,
        ST_READ      = 4'd6,
        ST_READ_NACK = 4'd7,
        ST_STOP      = 4'd8
    } state_t;

endpackage

// File: rtl/i2c_controller_tick_gen.sv
// Quarter-period timebase: divides clk by CLK_DIV and tracks the quarter index within a bit.
// i_hold freezes the divider (used for SCL clock stretching); i_en low parks it at Q0, count 0.
module i2c_controller_tick_gen
    import i2c_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_en,
    input  logic     i_hold,
    output logic     o_quarter_tick,
    output quarter_t o_quarter,
    output logic     o_quarter_first
);

    localparam int unsigned CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam quarter_t      Q_LAST   = quarter_t'(QUARTERS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    quarter_t      r_quarter;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_quarter <= Q0;
        end else if (!i_en) begin
            r_cnt     <= '0;
            r_quarter <= Q0;
        end else if (!i_hold) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt     <= '0;
                r_quarter <= (r_quarter == Q_LAST) ? Q0 : quarter_t'(r_quarter + 2'd1);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_quarter_tick  = i_en && !i_hold && (r_cnt == CNT_LAST);
    assign o_quarter       = r_quarter;
    assign o_quarter_first = (r_cnt == '0);

endmodule

// File: rtl/i2c_controller_txn.sv
// Single-byte I2C initiator: START, {addr,rw}, one data byte, STOP on open-drain SCL/SDA.
// Define I2C_CONTROLLER_CLK_STRETCH_EN to let a target stretch SCL at each Q2 entry.
module i2c_controller_txn
    import i2c_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 7,
    parameter int unsigned CLK_DIV       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_req,
    input  logic                     rw,
    input  logic [ADDRESS_WIDTH-1:0] target_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     SDA_in,
    input  logic                     SCL_in,
    output logic                     SCL_out,
    output logic                     SDA_out,
    output logic                     busy,
    output logic                     done,
    output logic                     nack,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    state_t                r_state, w_state_nxt;
    logic [BW-1:0]         r_bit, w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
    logic [DATA_WIDTH-1:0] r_rd_data, w_rd_nxt;
    logic                  r_rw, w_rw_nxt;
    logic                  r_ack, w_ack_nxt;
    logic                  r_nack, w_nack_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_scl, w_sda;

    logic     w_quarter_tick;
    logic     w_quarter_first;
    quarter_t w_quarter;
    logic     w_hold;
    logic     w_bit_end;
    logic     w_sample;
    logic     w_scl_hi;

`ifdef I2C_CONTROLLER_CLK_STRETCH_EN
    assign w_hold = (w_quarter == Q2) && w_quarter_first && !SCL_in;
`else
    logic w_unused_scl_in;
    assign w_unused_scl_in = SCL_in;
    assign w_hold          = 1'b0;
`endif

    i2c_controller_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_en            (r_state != ST_IDLE),
        .i_hold          (w_hold),
        .o_quarter_tick  (w_quarter_tick),
        .o_quarter       (w_quarter),
        .o_quarter_first (w_quarter_first)
    );

    // Bit boundaries happen on the last cycle of Q3; bus sampling on the last cycle of Q2.
    assign w_bit_end = w_quarter_tick && (w_quarter == Q3);
    assign w_sample  = w_quarter_tick && (w_quarter == Q2);
    assign w_scl_hi  = (w_quarter == Q2) || (w_quarter == Q3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit     <= '0;
            r_tx      <= '0;
            r_wdata   <= '0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_rw      <= 1'b0;
            r_ack     <= 1'b0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit     <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rx      <= w_rx_nxt;
            r_rd_data <= w_rd_nxt;
            r_rw      <= w_rw_nxt;
            r_ack     <= w_ack_nxt;
            r_nack    <= w_nack_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_tx_nxt    = r_tx;
        w_wdata_nxt = r_wdata;
        w_rx_nxt    = r_rx;
        w_rd_nxt    = r_rd_data;
        w_rw_nxt    = r_rw;
        w_ack_nxt   = r_ack;
        w_nack_nxt  = r_nack;
        w_done_nxt  = 1'b0;
        w_scl       = 1'b1;
        w_sda       = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (start_req) begin
                    w_state_nxt = ST_START;
                    w_tx_nxt    = DATA_WIDTH'({target_addr, rw});
                    w_wdata_nxt = wr_data;
                    w_rw_nxt    = rw;
                    w_nack_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                    w_rx_nxt    = '0;
                end
            end
            ST_START: begin
                w_sda = !w_scl_hi;
                if (w_bit_end) w_state_nxt = ST_ADDR;
            end
            ST_ADDR, ST_WRITE: begin
                w_scl = w_scl_hi;
                w_sda = r_tx[DATA_WIDTH-1];
                if (w_bit_end) begin
                    w_tx_nxt = {r_tx[DATA_WIDTH-2:0], 1'b0};
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (r_state == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            ST_ADDR_ACK: begin
                w_scl = w_scl_hi;
                if (w_sample) w_ack_nxt = SDA_in;
                if (w_bit_end) begin
                    if (r_ack) begin
                        w_nack_nxt  = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else if (r_rw) begin
                        w_state_nxt = ST_READ;
                    end else begin
                        w_tx_nxt    = r_wdata;
                        w_state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE_ACK: begin
                w_scl = w_scl_hi;
                if (w_sample) w_ack_nxt = SDA_in;
                if (w_bit_end) begin
                    w_nack_nxt  = r_ack;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_READ: begin
                w_scl = w_scl_hi;
                if (w_sample) w_rx_nxt = {r_rx[DATA_WIDTH-2:0], SDA_in};
                if (w_bit_end) begin
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_READ_NACK;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            ST_READ_NACK: begin
                w_scl = w_scl_hi;
                if (w_bit_end) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // SDA rises while SCL is already high: the bus STOP condition.
                w_scl = (w_quarter != Q0);
                w_sda = w_scl_hi;
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    if (r_rw) w_rd_nxt = r_rx;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign SCL_out = w_scl;
    assign SDA_out = w_sda;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign nack    = r_nack;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_i2c_controller_txn.sv
// Scoreboarded bench for i2c_controller_txn with a behavioural I2C target on the bus.
// Define I2C_CONTROLLER_CLK_STRETCH_EN to also exercise SCL stretching.
module tb_i2c_controller_txn;
    import i2c_controller_pkg::*;

    localparam int unsigned CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] target_addr = '0;
    logic [7:0] wr_data = '0;
    logic       SCL_out, SDA_out, busy, done, nack;
    logic [7:0] rd_data;

    logic tgt_sda = 1'b1;
    logic tgt_scl = 1'b1;
    logic sda_bus, scl_bus;
    assign sda_bus = SDA_out & tgt_sda;
    assign scl_bus = SCL_out & tgt_scl;

    i2c_controller_txn #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (7),
        .CLK_DIV       (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_req   (start_req),
        .rw          (rw),
        .target_addr (target_addr),
        .wr_data     (wr_data),
        .SDA_in      (sda_bus),
        .SCL_in      (scl_bus),
        .SCL_out     (SCL_out),
        .SDA_out     (SDA_out),
        .busy        (busy),
        .done        (done),
        .nack        (nack),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        addr_ack;
        logic        exp_nack;
        logic        rd_chk;
        logic [7:0]  exp_rd;
        int unsigned exp_done;
    } exp_t;
    exp_t sb[$];

    // Reference state for rd_data: last successfully read byte (cleared by reset).
    logic [7:0] m_rd = '0;
    logic       m_rd_valid = 1'b1;

    // Target configuration, set before each request.
    logic [7:0] tgt_rd_cfg = '0;
    logic       tgt_dnack_cfg = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural target at address I2C_DEFAULT_ADDR; counts SCL edges after a START.
    logic       t_active = 1'b0, t_prev_scl = 1'b1, t_prev_sda = 1'b1;
    logic       t_s, t_c, t_match, t_ninth = 1'b0, t_last_ninth = 1'b0;
    logic [7:0] t_addr = '0, t_data = '0, t_last_addr = '0, t_last_data = '0;
    int         t_rise = 0, t_fall = 0;

    always @(negedge clk) begin
        if (rst) begin
            tgt_sda    = 1'b1;
            t_active   = 1'b0;
            t_prev_scl = 1'b1;
            t_prev_sda = 1'b1;
        end else begin
            t_s = sda_bus;
            t_c = scl_bus;
            if (t_c && t_prev_scl && t_prev_sda && !t_s) begin
                t_active = 1'b1; t_rise = 0; t_fall = 0;
                t_addr = '0; t_data = '0; t_ninth = 1'b0;
            end else if (t_c && t_prev_scl && !t_prev_sda && t_s) begin
                if (t_active) begin
                    t_last_addr = t_addr; t_last_data = t_data; t_last_ninth = t_ninth;
                end
                t_active = 1'b0;
                tgt_sda  = 1'b1;
            end else if (t_active) begin
                if (t_c && !t_prev_scl) begin
                    t_rise++;
                    if (t_rise <= 8) t_addr = {t_addr[6:0], t_s};
                    else if (t_rise >= 10 && t_rise <= 17) t_data = {t_data[6:0], t_s};
                    else if (t_rise == 18) t_ninth = t_s;
                end
                if (!t_c && t_prev_scl) begin
                    t_fall++;
                    t_match = (t_addr[7:1] == I2C_DEFAULT_ADDR);
                    if (t_fall == 9) tgt_sda = !t_match;
                    else if (t_fall >= 10 && t_fall <= 17)
                        tgt_sda = (t_match && t_addr[0]) ? tgt_rd_cfg[17 - t_fall] : 1'b1;
                    else if (t_fall == 18) tgt_sda = !(t_match && !t_addr[0] && !tgt_dnack_cfg);
                    else tgt_sda = 1'b1;
                end
            end
            t_prev_scl = t_c;
            t_prev_sda = t_s;
        end
    end

    // SCL stretcher: pulls SCL low before a Q2 and keeps it low for 20 held edges.
    logic st_arm = 1'b0, st_fired = 1'b0, st_phase = 1'b0;
    int   st_cnt = 0;
    always @(negedge clk) begin
        if (st_arm && !st_fired && !st_phase && SCL_out == 1'b0) begin
            tgt_scl = 1'b0; st_phase = 1'b1; st_fired = 1'b1; st_cnt = 0;
        end else if (st_phase && SCL_out == 1'b1) begin
            st_cnt++;
            if (st_cnt == 21) begin
                tgt_scl = 1'b1; st_phase = 1'b0;
            end
        end
    end

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.exp_done);
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("nack", 32'(nack), 32'(e.exp_nack));
                    if (e.rd_chk) chk("rd_data", 32'(rd_data), 32'(e.exp_rd));
                    chk("addr_byte_on_bus", 32'(t_last_addr), 32'({e.addr, e.rw}));
                    if (e.addr_ack && !e.rw) chk("wdata_on_bus", 32'(t_last_data), 32'(e.wdata));
                    if (e.addr_ack && e.rw) chk("read_ninth_bit_released", 32'(t_last_ninth), 32'd1);
                end
            end
        end
    endtask

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic [7:0] rdv, input logic dn,
                         input int unsigned pulse_at, input logic stretch);
        exp_t        e;
        int unsigned t0;
        int unsigned waited;
        @(negedge clk);
        tgt_rd_cfg    = rdv;
        tgt_dnack_cfg = dn;
        target_addr   = a;
        rw            = r;
        wr_data       = wd;
        start_req     = 1'b1;
        t0            = cyc;
        e.addr     = a;
        e.rw       = r;
        e.wdata    = wd;
        e.addr_ack = (a == I2C_DEFAULT_ADDR);
        e.exp_nack = !e.addr_ack || (!r && dn);
        e.exp_done = t0 + 4 * CLK_DIV * (e.addr_ack ? 20 : 11) + 1 + (stretch ? 20 : 0);
        if (r && e.addr_ack) begin
            e.rd_chk = 1'b1; e.exp_rd = rdv; m_rd = rdv; m_rd_valid = 1'b1;
        end else if (r) begin
            e.rd_chk = 1'b0; e.exp_rd = '0; m_rd_valid = 1'b0;
        end else begin
            e.rd_chk = m_rd_valid; e.exp_rd = m_rd;
        end
        sb.push_back(e);
        @(negedge clk);
        start_req   = 1'b0;
        target_addr = 7'($urandom);
        rw          = 1'($urandom);
        wr_data     = 8'($urandom);
        if (stretch) begin
            st_arm = 1'b1; st_fired = 1'b0;
        end
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (pulse_at != 0) begin
            while (cyc < t0 + pulse_at) @(negedge clk);
            start_req   = 1'b1;
            target_addr = 7'($urandom);
            rw          = 1'($urandom);
            @(negedge clk);
            start_req = 1'b0;
        end
        waited = 0;
        while (sb.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        st_arm = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done by cycle %0d", waited, sb[0].exp_done);
            sb.delete();
        end
    endtask

    initial begin
        logic [6:0]  a;
        int unsigned t0;
        fork
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_scl", 32'(SCL_out), 32'd1);
        chk("reset_sda", 32'(SDA_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_nack", 32'(nack), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(7'h01, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 1'b0);
        issue(7'h01, 1'b1, 8'h00, 8'h3C, 1'b0, 0, 1'b0);
        issue(7'h22, 1'b0, 8'h5A, 8'h00, 1'b0, 0, 1'b0);
        issue(7'h01, 1'b0, 8'h96, 8'h00, 1'b0, 50, 1'b0);
        issue(7'h01, 1'b0, 8'h0F, 8'h00, 1'b1, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 1) == 1) ? I2C_DEFAULT_ADDR : 7'($urandom);
            if (i % 4 == 1) a = 7'h7F;
            issue(a, 1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                  (i % 3 == 0) ? $urandom_range(20, 150) : 0, 1'b0);
        end

        // Reset in the middle of a write's data byte.
        @(negedge clk);
        target_addr = 7'h01; rw = 1'b0; wr_data = 8'hC3; start_req = 1'b1; t0 = cyc;
        @(negedge clk);
        start_req = 1'b0;
        while (cyc < t0 + 200) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_scl", 32'(SCL_out), 32'd1);
        chk("midreset_sda", 32'(SDA_out), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_rd = '0; m_rd_valid = 1'b1;
        repeat (400) @(negedge clk);
        chk("post_reset_rd_data", 32'(rd_data), 32'd0);

        issue(7'h01, 1'b0, 8'h81, 8'h00, 1'b0, 0, 1'b0);
        issue(7'h01, 1'b1, 8'h00, 8'hE7, 1'b0, 0, 1'b0);

`ifdef I2C_CONTROLLER_CLK_STRETCH_EN
        issue(7'h01, 1'b0, 8'h3D, 8'h00, 1'b0, 0, 1'b1);
        issue(7'h01, 1'b1, 8'h00, 8'h5B, 1'b0, 0, 1'b1);
`endif

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
